onoff_sequencer: RTL and testbench
==================================

Name: onoff_sequencer

Overview:
- Duty-cycle scheduler for the two-state on/off output stage.
- Drives the stage's 1-bit select, 0 = on, 1 = off.
- Runs a programmed number of on/off repetitions with programmable phase lengths.
- Mirrors the stage's 2-bit output code and reports progress to the host via a start/busy/done handshake.

Parameters:
- CNT_W, 8: width of the phase-length inputs and the phase counter.
- REP_W, 4: width of the repetition count.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- start  input  1  begin a sequence; sampled only in IDLE
- on_len  input  CNT_W  on-phase length in cycles; latched on accepted start
- off_len  input  CNT_W  off-phase length in cycles; latched on accepted start
- reps  input  REP_W  number of on/off repetitions; latched on accepted start
- abort  input  1  terminate the sequence early
- stage_sel  output  1  drive to the on/off stage (0 = on, 1 = off)
- out_code  output  2  0x0 idle/done, 0x1 on, 0x3 off
- busy  output  1  high in ON and OFF
- done  output  1  one-cycle completion pulse
- reps_left  output  REP_W  repetitions remaining, including the current one
- phase_cnt  output  CNT_W  cycles remaining in the current phase, minus 1

Interface rule: reset rst, synchronous, active-high; clock clk.

Behaviour:
- States: IDLE, ON, OFF, DONE.
- All outputs are registered.
- Reset values: state IDLE, stage_sel=1, out_code=0, busy=0, done=0, reps_left=0, phase_cnt=0.
- Reset mid-sequence returns to IDLE on the next edge with no done pulse.
- IDLE:
  - stage_sel=1, out_code=0.
  - On start, latch all three inputs.
  - If reps==0 or on_len==0: go to DONE.
  - Otherwise: go to ON with phase_cnt=on_len-1 and reps_left=reps.
  - Start at edge T gives ON visible from T+1.
- ON:
  - stage_sel=0, out_code=1.
  - phase_cnt decrements each cycle.
  - When phase_cnt==0 and off_len!=0: go to OFF with phase_cnt=off_len-1.
  - When phase_cnt==0 and off_len==0: act as OFF expiry, i.e. apply the repetition rule directly.
  - On phase lasts exactly on_len cycles.
- OFF:
  - stage_sel=1, out_code=3.
  - When phase_cnt==0: if reps_left==1 go to DONE, else decrement reps_left and go to ON with phase_cnt=on_len-1.
- DONE:
  - done=1 for one cycle, stage_sel=1, out_code=0, reps_left=0.
  - Next state is IDLE.
- abort:
  - In ON or OFF, go to DONE next cycle.
  - abort takes priority over phase expiry in the same cycle.
  - abort is ignored in IDLE and DONE.
- start while busy or in DONE is ignored; it is not queued.
- start and abort together in IDLE: start is accepted.
- Counter arithmetic:
  - Unsigned, no wrap is reachable.
  - The load values on_len-1 and off_len-1 are used only when the length is nonzero.
- Total sequence length is reps*(on_len+off_len) cycles, followed by 1 DONE cycle.

Optional Feature:
- Macro: ONOFF_SEQUENCER_ABORT_STATUS_EN
- Defined:
  - Adds output port aborted (1 bit), reset 0.
  - aborted is high coincident with done only when DONE was entered via abort, otherwise 0.
- Undefined:
  - No port.
  - Abort-terminated and normally completed sequences are indistinguishable, apart from reps_left before DONE.

Decomposition:
- Package onoff_seq_pkg holds:
  - the state enum (IDLE, ON, OFF, DONE);
  - output-code constants CODE_IDLE=2'h0, CODE_ON=2'h1, CODE_OFF=2'h3;
  - select constants SEL_ON=1'b0, SEL_OFF=1'b1.
- One sub-module, onoff_phase_timer:
  - CNT_W-bit loadable down-counter;
  - inputs load and load_val;
  - outputs count and expired (count==0).
  - The FSM stays in the top module.

Test Plan:
- Reset then idle: all outputs at reset values; start=0 for 10 cycles -> no change.
- on_len=3, off_len=2, reps=2, start pulse:
  - stage_sel reads 0,0,0,1,1,0,0,0,1,1, then done=1 on the 11th cycle;
  - out_code follows 1/3, then 0.
- off_len=0, on_len=4, reps=3 -> stage_sel 0 for 12 consecutive cycles, then done; out_code is never 3.
- reps=0 or on_len=0 start -> done pulse at T+1, busy never asserted.
- Abort in second ON phase, coincident with phase_cnt==0 -> DONE next cycle, no OFF entered; with macro defined, aborted=1 with done.
- Start held high through a whole sequence -> exactly one sequence per IDLE entry; rst mid-OFF -> IDLE, stage_sel=1, no done.

Source files
------------

// File: rtl/onoff_seq_pkg.sv
// Shared types and constants for the on/off duty-cycle sequencer.
// Used by onoff_sequencer and onoff_phase_timer.
package onoff_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] CODE_IDLE = 2'h0;
    localparam logic [1:0] CODE_ON   = 2'h1;
    localparam logic [1:0] CODE_OFF  = 2'h3;

    localparam logic SEL_ON  = 1'b0;
    localparam logic SEL_OFF = 1'b1;

endpackage

// File: rtl/onoff_phase_timer.sv
// Loadable down-counter timing one on or off phase; holds at zero once expired.
module onoff_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/onoff_sequencer.sv
// Duty-cycle scheduler driving the on/off stage select with a start/busy/done handshake.
// Optional build macro ONOFF_SEQUENCER_ABORT_STATUS_EN adds the 'aborted' status output.
module onoff_sequencer
    import onoff_seq_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] on_len,
    input  logic [CNT_W-1:0] off_len,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    output logic             stage_sel,
    output logic [1:0]       out_code,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] reps_left,
    output logic [CNT_W-1:0] phase_cnt
`ifdef ONOFF_SEQUENCER_ABORT_STATUS_EN
    ,
    output logic             aborted
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] on_len_q;
    logic [CNT_W-1:0] off_len_q;
    logic [REP_W-1:0] reps_left_nxt;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expired;
    logic             rep_end;

    onoff_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .count   (phase_cnt),
        .expired (tmr_expired)
    );

    // Phase lengths are only consumed after an accepted start, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            on_len_q  <= on_len;
            off_len_q <= off_len;
        end
    end

    always_comb begin
        state_nxt     = state;
        reps_left_nxt = reps_left;
        tmr_load      = 1'b0;
        tmr_val       = '0;
        rep_end       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (reps == '0 || on_len == '0) begin
                        state_nxt     = DONE;
                        tmr_load      = 1'b1;
                        reps_left_nxt = '0;
                    end else begin
                        state_nxt     = ON;
                        tmr_load      = 1'b1;
                        tmr_val       = on_len - CNT_W'(1);
                        reps_left_nxt = reps;
                    end
                end
            end
            ON: begin
                if (abort) begin
                    state_nxt     = DONE;
                    tmr_load      = 1'b1;
                    reps_left_nxt = '0;
                end else if (tmr_expired) begin
                    if (off_len_q != '0) begin
                        state_nxt = OFF;
                        tmr_load  = 1'b1;
                        tmr_val   = off_len_q - CNT_W'(1);
                    end else begin
                        rep_end = 1'b1;
                    end
                end
            end
            OFF: begin
                if (abort) begin
                    state_nxt     = DONE;
                    tmr_load      = 1'b1;
                    reps_left_nxt = '0;
                end else if (tmr_expired) begin
                    rep_end = 1'b1;
                end
            end
            DONE: begin
                state_nxt     = IDLE;
                reps_left_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // End of one on/off repetition: either finish or start the next on phase.
        if (rep_end) begin
            tmr_load = 1'b1;
            if (reps_left == REP_W'(1)) begin
                state_nxt     = DONE;
                reps_left_nxt = '0;
            end else begin
                state_nxt     = ON;
                tmr_val       = on_len_q - CNT_W'(1);
                reps_left_nxt = reps_left - REP_W'(1);
            end
        end
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stage_sel <= SEL_OFF;
            out_code  <= CODE_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            reps_left <= '0;
        end else begin
            state     <= state_nxt;
            stage_sel <= (state_nxt == ON) ? SEL_ON : SEL_OFF;
            busy      <= (state_nxt == ON) || (state_nxt == OFF);
            done      <= (state_nxt == DONE);
            reps_left <= reps_left_nxt;
            case (state_nxt)
                ON:      out_code <= CODE_ON;
                OFF:     out_code <= CODE_OFF;
                default: out_code <= CODE_IDLE;
            endcase
        end
    end

`ifdef ONOFF_SEQUENCER_ABORT_STATUS_EN
    // Abort always wins in ON/OFF, so this alone identifies an abort-driven DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            aborted <= 1'b0;
        end else begin
            aborted <= abort && (state == ON || state == OFF);
        end
    end
`endif

endmodule

// File: tb/tb_onoff_sequencer.sv
// Self-checking bench for onoff_sequencer: vector table, hand-written corner sequences
// and randomized sequences against a trace-expanding reference model.
module tb_onoff_sequencer;

    localparam int CNT_W = 8;
    localparam int REP_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] on_len;
    logic [CNT_W-1:0] off_len;
    logic [REP_W-1:0] reps;
    logic             stage_sel;
    logic [1:0]       out_code;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] reps_left;
    logic [CNT_W-1:0] phase_cnt;
`ifdef ONOFF_SEQUENCER_ABORT_STATUS_EN
    logic             aborted;
`endif

    int checks = 0;
    int errors = 0;

    onoff_sequencer #(
        .CNT_W(CNT_W),
        .REP_W(REP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .on_len   (on_len),
        .off_len  (off_len),
        .reps     (reps),
        .abort    (abort),
        .stage_sel(stage_sel),
        .out_code (out_code),
        .busy     (busy),
        .done     (done),
        .reps_left(reps_left),
        .phase_cnt(phase_cnt)
`ifdef ONOFF_SEQUENCER_ABORT_STATUS_EN
        ,
        .aborted  (aborted)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int on;
        int off;
        int rp;
        int act;
        int offc;
    } vec_t;

    logic [31:0] q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed view {aborted, sel, code, busy, done, reps_left, phase_cnt}.
    function automatic logic [31:0] pack(input int sel, input int code, input int bsy,
                                         input int dn, input int rl, input int pc, input int ab);
        logic [31:0] v;
        v = 32'({1'b0, sel[0], code[1:0], bsy[0], dn[0], rl[3:0], pc[7:0]});
`ifdef ONOFF_SEQUENCER_ABORT_STATUS_EN
        v[17] = ab[0];
`endif
        return v;
    endfunction

    function automatic logic [31:0] obs();
        logic [31:0] v;
        v = 32'({1'b0, stage_sel, out_code, busy, done, reps_left, phase_cnt});
`ifdef ONOFF_SEQUENCER_ABORT_STATUS_EN
        v[17] = aborted;
`endif
        return v;
    endfunction

    // Expands a sequence into its per-cycle expected trace, cut short by an abort.
    task automatic build(input int on, input int off, input int rp, input int abort_at);
        bit was_ab;
        q.delete();
        if (rp > 0 && on > 0) begin
            for (int r = 0; r < rp; r++) begin
                for (int j = 0; j < on; j++)  q.push_back(pack(0, 1, 1, 0, rp - r, on - 1 - j, 0));
                for (int j = 0; j < off; j++) q.push_back(pack(1, 3, 1, 0, rp - r, off - 1 - j, 0));
            end
        end
        was_ab = (abort_at >= 0) && (abort_at < q.size());
        if (was_ab) begin
            while (q.size() > abort_at + 1) q.delete(q.size() - 1);
        end
        q.push_back(pack(1, 0, 0, 1, 0, 0, int'(was_ab)));
        q.push_back(pack(1, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic run_seq(input int on, input int off, input int rp, input int abort_at,
                           input bit abort_w_start, input string nm);
        build(on, off, rp, abort_at);
        on_len  = CNT_W'(on);
        off_len = CNT_W'(off);
        reps    = REP_W'(rp);
        start   = 1'b1;
        abort   = abort_w_start;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            chk($sformatf("%s cyc%0d", nm, i), obs(), q[i]);
            if (i == abort_at) abort = 1'b1;
            step();
            abort = 1'b0;
        end
    endtask

    vec_t tbl[8];

    initial begin
        logic [9:0]  sel_seen;
        logic [11:0] code_seen;
        logic [5:0]  done_seen;
        int act, offc, ab_at, on, off, rp;

        tbl[0] = '{3, 2, 2, 10, 4};
        tbl[1] = '{4, 0, 3, 12, 0};
        tbl[2] = '{0, 5, 2, 0, 0};
        tbl[3] = '{5, 1, 0, 0, 0};
        tbl[4] = '{1, 1, 1, 2, 1};
        tbl[5] = '{2, 3, 3, 15, 9};
        tbl[6] = '{1, 0, 1, 1, 0};
        tbl[7] = '{200, 50, 2, 500, 100};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        on_len = '0; off_len = '0; reps = '0;
        step();
        step();
        chk("reset_state", obs(), pack(1, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle_hold%0d", i), obs(), pack(1, 0, 0, 0, 0, 0, 0));
        end

        // Table of whole sequences: active cycles, off cycles, done seen.
        for (int t = 0; t < 8; t++) begin
            on_len = CNT_W'(tbl[t].on); off_len = CNT_W'(tbl[t].off); reps = REP_W'(tbl[t].rp);
            start = 1'b1;
            step();
            start = 1'b0;
            act = 0; offc = 0;
            for (int n = 0; n < 2000; n++) begin
                if (done) break;
                if (busy) act++;
                if (out_code == 2'h3) offc++;
                step();
            end
            chk($sformatf("tbl%0d done", t), 32'(done), 32'd1);
            chk($sformatf("tbl%0d active", t), act, tbl[t].act);
            chk($sformatf("tbl%0d offcyc", t), offc, tbl[t].offc);
            step();
        end

        // Explicit select pattern for on=3 off=2 reps=2.
        on_len = 8'd3; off_len = 8'd2; reps = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sel_seen[9 - i] = stage_sel;
            step();
        end
        chk("sel_pattern", 32'(sel_seen), 32'b0001100011);
        chk("sel_pattern_done", 32'(done), 32'd1);
        step();

        run_seq(3, 2, 2, -1, 1'b0, "basic");
        run_seq(4, 0, 3, -1, 1'b0, "off0");
        run_seq(0, 3, 2, -1, 1'b0, "on0");
        run_seq(3, 2, 0, -1, 1'b0, "reps0");
        run_seq(3, 2, 2, 7, 1'b0, "abort_expiry");
        run_seq(2, 2, 1, -1, 1'b1, "start_abort");

        // Start held high: one sequence per IDLE entry.
        on_len = 8'd2; off_len = 8'd1; reps = 4'd1;
        start = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            code_seen[11 - 2*i -: 2] = out_code;
            done_seen[5 - i] = done;
            step();
        end
        start = 1'b0;
        chk("held_codes", 32'(code_seen), 32'b010111000001);
        chk("held_done", 32'(done_seen), 32'b000100);
        for (int i = 0; i < 3; i++) step();
        chk("held_idle", obs(), pack(1, 0, 0, 0, 0, 0, 0));

        // Reset in the middle of the off phase.
        on_len = 8'd2; off_len = 8'd3; reps = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_rst_off", 32'(out_code), 32'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_off", obs(), pack(1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rst_no_done%0d", i), 32'({done, busy, stage_sel}), 32'b001);
        end

        // Randomized sequences with occasional abort, including in DONE.
        for (int k = 0; k < 60; k++) begin
            on  = int'($urandom_range(0, 5));
            off = int'($urandom_range(0, 4));
            rp  = int'($urandom_range(0, 3));
            ab_at = -1;
            if ($urandom_range(0, 1) == 1) ab_at = int'($urandom_range(0, rp * (on + off)));
            run_seq(on, off, rp, ab_at, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
